csr_arbiter: RTL and testbench
==============================

# csr_arbiter

Two-requester arbiter for the application's single-ported CSR access bus (valid / write_enable / address / write_data / read_data) into the CSR register file or the CSR DPRAM port. It lets the host-side AXI-Lite bridge (requester 0, HOST) and an on-card engine (requester 1, APP) share one CSR target. It registers the issued access, tracks in-flight reads through the target's fixed read latency, and returns each read to its owner through a per-requester response FIFO with credit-based flow control.

## Interface
Parameters:
- DATA_WIDTH, 32, CSR data width.
- ADDRESS_WIDTH, 8, CSR word-address width.
- READ_LATENCY, 1, cycles from the CSR_valid read cycle to valid CSR_read_data; legal range 1..4.
- RSP_DEPTH, 2, response FIFO entries per requester; legal range 1..8.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- HOST_req_valid / APP_req_valid  in  1  request pending; held stable until accepted.
- HOST_req_ready / APP_req_ready  out  1  request accepted this cycle; combinational, may depend on req_valid.
- HOST_req_write / APP_req_write  in  1  1 = write, 0 = read.
- HOST_req_address / APP_req_address  in  ADDRESS_WIDTH  word address.
- HOST_req_wdata / APP_req_wdata  in  DATA_WIDTH  write data.
- HOST_rsp_valid / APP_rsp_valid  out  1  read response available.
- HOST_rsp_ready / APP_rsp_ready  in  1  response consumed.
- HOST_rsp_rdata / APP_rsp_rdata  out  DATA_WIDTH  read data.
- CSR_valid  out  1  access strobe, one cycle per access.
- CSR_write_enable  out  1  write qualifier.
- CSR_address  out  ADDRESS_WIDTH  word address.
- CSR_write_data  out  DATA_WIDTH  write data.
- CSR_read_data  in  DATA_WIDTH  target read data.

## Operation
- Eligibility:
  - A write request is always eligible.
  - A read request is eligible only if that requester's outstanding count is below RSP_DEPTH. Outstanding count = FIFO occupancy + reads in flight, taken from registered values at the start of the cycle.
- Grant: at most one accept per cycle.
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester not granted last wins (round-robin).
  - last_grant updates only on an accept.
- Accept: req_ready is asserted only in the cycle the grant is given and valid is high. An ineligible requester sees req_ready = 0 and waits. Writes never produce a response.
- Issue register: the accepted request is registered onto the CSR_* outputs for exactly one cycle.
  - CSR_write_enable = req_write.
  - CSR_valid is 0 in all other cycles; other CSR_* outputs then hold their last value.
- Read tracking:
  - A READ_LATENCY+1 deep shift register carries {valid, owner} per issued read.
  - The entry reaching the end captures CSR_read_data into the owner's FIFO.
  - In-flight count per requester = entries in the shift register owned by that requester.
- Response FIFO per requester, RSP_DEPTH entries, first-word-fall-through.
  - rsp_valid = FIFO not empty; rsp_rdata = head entry.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are legal at any occupancy.
  - The credit rule guarantees no overflow; an overflow is a design error (assertion).
  - A pop frees a credit starting the next cycle.
- Reset (asynchronous, mid-operation included) clears:
  - FIFOs;
  - the tracking pipeline, so in-flight reads are discarded;
  - last_grant, set to APP, so HOST wins the first conflict.
- Output reset values: all CSR_* = 0, all rsp_valid = 0, rsp_rdata = 0, req_ready = 0.

## Timing
- Request accepted in cycle T → CSR_valid high in cycle T+1.
- Read data sampled at the end of cycle T+1+READ_LATENCY → rsp_valid high from cycle T+2+READ_LATENCY. With the default parameters this is 3 cycles after accept.
- Throughput: one access per cycle across both requesters. Back-to-back accepts from the same requester are allowed when the other requester is idle.
- With RSP_DEPTH=2 and READ_LATENCY=1, a single requester with rsp_ready held high sustains 2 reads per 4 cycles. This is credit-limited.

## Configuration
- CSR_ARBITER_HOST_PRIORITY_EN:
  - Defined: on conflict, HOST always wins; APP is granted only when HOST is not eligible. last_grant is unused.
  - Undefined: round-robin as above.

## Test plan
- Single HOST write, addr 0x05, data 0xDEADBEEF → HOST_req_ready in T; in T+1, CSR_valid=1, CSR_write_enable=1, CSR_address=0x05, CSR_write_data=0xDEADBEEF; no HOST_rsp_valid.
- Single APP read, addr 0x10; target returns 0x12345678 → CSR_valid read in T+1; APP_rsp_valid in T+3 with rdata 0x12345678; HOST_rsp_valid stays 0.
- Both requesters hold reads continuously, rsp_ready=1 → accepts alternate HOST, APP, HOST, …; HOST goes first after reset. With the macro defined, HOST takes every cycle it is eligible.
- HOST issues 3 reads back-to-back with HOST_rsp_ready=0 (RSP_DEPTH=2) → first 2 accepted, third stalls with req_ready=0. Raising rsp_ready for one pop → third accepted the cycle after the pop.
- HOST read and APP write interleaved; reads return 0xA, 0xB in order → HOST responses in issue order; APP write visible on CSR bus; no cross-delivery.
- Assert reset_n=0 one cycle after a read is issued → all outputs reset immediately; after release, no stale rsp_valid appears.

Source files
------------

// File: rtl/csr_arbiter_if.sv
// rtl/csr_arbiter_if.sv - request/response and CSR target signal bundle for csr_arbiter
//
// Groups every non-clock signal of csr_arbiter:
//   HOST_req_* / APP_req_*  : request channel per requester (valid/ready/write/address/wdata)
//   HOST_rsp_* / APP_rsp_*  : read response channel per requester (valid/ready/rdata)
//   CSR_*                   : single-ported CSR target access bus
// Modports:
//   slave  : the arbiter's view (accepts requests, drives responses and the CSR bus)
//   master : the requesters' / target's view (drives requests, consumes responses, returns read data)
interface csr_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8
);
  logic                     HOST_req_valid;
  logic                     HOST_req_ready;
  logic                     HOST_req_write;
  logic [ADDRESS_WIDTH-1:0] HOST_req_address;
  logic [DATA_WIDTH-1:0]    HOST_req_wdata;
  logic                     HOST_rsp_valid;
  logic                     HOST_rsp_ready;
  logic [DATA_WIDTH-1:0]    HOST_rsp_rdata;

  logic                     APP_req_valid;
  logic                     APP_req_ready;
  logic                     APP_req_write;
  logic [ADDRESS_WIDTH-1:0] APP_req_address;
  logic [DATA_WIDTH-1:0]    APP_req_wdata;
  logic                     APP_rsp_valid;
  logic                     APP_rsp_ready;
  logic [DATA_WIDTH-1:0]    APP_rsp_rdata;

  logic                     CSR_valid;
  logic                     CSR_write_enable;
  logic [ADDRESS_WIDTH-1:0] CSR_address;
  logic [DATA_WIDTH-1:0]    CSR_write_data;
  logic [DATA_WIDTH-1:0]    CSR_read_data;

  modport slave (
    input  HOST_req_valid, HOST_req_write, HOST_req_address, HOST_req_wdata, HOST_rsp_ready,
    output HOST_req_ready, HOST_rsp_valid, HOST_rsp_rdata,
    input  APP_req_valid, APP_req_write, APP_req_address, APP_req_wdata, APP_rsp_ready,
    output APP_req_ready, APP_rsp_valid, APP_rsp_rdata,
    output CSR_valid, CSR_write_enable, CSR_address, CSR_write_data,
    input  CSR_read_data
  );

  modport master (
    output HOST_req_valid, HOST_req_write, HOST_req_address, HOST_req_wdata, HOST_rsp_ready,
    input  HOST_req_ready, HOST_rsp_valid, HOST_rsp_rdata,
    output APP_req_valid, APP_req_write, APP_req_address, APP_req_wdata, APP_rsp_ready,
    input  APP_req_ready, APP_rsp_valid, APP_rsp_rdata,
    input  CSR_valid, CSR_write_enable, CSR_address, CSR_write_data,
    output CSR_read_data
  );
endinterface

// File: rtl/csr_arbiter.sv
// rtl/csr_arbiter.sv - two-requester CSR bus arbiter with read tracking and credit-limited response FIFOs
//
// Ports:
//   clock   : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : csr_arbiter_if.slave (HOST/APP request + response channels, CSR target bus)
// Optional feature macro:
//   CSR_ARBITER_HOST_PRIORITY_EN : defined -> HOST always wins a conflict; undefined -> round-robin.
module csr_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int READ_LATENCY  = 1,
  parameter int RSP_DEPTH     = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  csr_arbiter_if.slave bus
);
  localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W  = 5;  // occupancy (<=8) plus in-flight (<=5)
  localparam int STAGES = READ_LATENCY + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  // Requester index: 0 = HOST, 1 = APP
  logic [1:0]               w_req_valid, w_req_write;
  logic [ADDRESS_WIDTH-1:0] w_req_addr  [2];
  logic [DATA_WIDTH-1:0]    w_req_wdata [2];
  logic [1:0]               w_elig, w_grant, w_push, w_pop;
  logic [CNT_W-1:0]         w_inflight    [2];
  logic [CNT_W-1:0]         w_outstanding [2];
  logic                     w_accept, w_sel;

  // Read tracking pipeline: bit 0 is the read issued this cycle, bit STAGES-1 is the one whose
  // data is on CSR_read_data now.
  logic [STAGES-1:0]        r_pipe_valid, r_pipe_owner;

  logic [DATA_WIDTH-1:0]    r_mem   [2][RSP_DEPTH];
  logic [PTR_W-1:0]         r_wptr  [2];
  logic [PTR_W-1:0]         r_rptr  [2];
  logic [CNT_W-1:0]         r_count [2];

  logic                     r_csr_valid, r_csr_we;
  logic [ADDRESS_WIDTH-1:0] r_csr_addr;
  logic [DATA_WIDTH-1:0]    r_csr_wdata;

  assign w_req_valid    = {bus.APP_req_valid, bus.HOST_req_valid};
  assign w_req_write    = {bus.APP_req_write, bus.HOST_req_write};
  assign w_req_addr[0]  = bus.HOST_req_address;
  assign w_req_addr[1]  = bus.APP_req_address;
  assign w_req_wdata[0] = bus.HOST_req_wdata;
  assign w_req_wdata[1] = bus.APP_req_wdata;

  // Credits: a read may only be accepted while every response it could produce has a FIFO slot.
  always_comb begin
    w_elig = '0;
    for (int r = 0; r < 2; r++) begin
      w_inflight[r] = '0;
      for (int s = 0; s < STAGES; s++) begin
        if (r_pipe_valid[s] && (r_pipe_owner[s] == r[0])) begin
          w_inflight[r] = w_inflight[r] + CNT_W'(1);
        end
      end
      w_outstanding[r] = r_count[r] + w_inflight[r];
      w_elig[r] = w_req_valid[r] && (w_req_write[r] || (w_outstanding[r] < DEPTH_C));
    end
  end

`ifdef CSR_ARBITER_HOST_PRIORITY_EN
  always_comb begin
    w_grant    = '0;
    w_grant[0] = w_elig[0];
    w_grant[1] = w_elig[1] && !w_grant[0];
  end
`else
  logic r_last_grant;  // 0 = HOST, 1 = APP

  always_comb begin
    w_grant    = '0;
    w_grant[0] = w_elig[0] && (!w_elig[1] || r_last_grant);
    w_grant[1] = w_elig[1] && !w_grant[0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;  // HOST wins the first conflict
    end else if (w_accept) begin
      r_last_grant <= w_sel;
    end
  end
`endif

  assign w_accept = |w_grant;
  assign w_sel    = w_grant[1];

  // Ready is combinational; gating with reset_n keeps it low while reset is held.
  assign bus.HOST_req_ready = w_grant[0] & reset_n;
  assign bus.APP_req_ready  = w_grant[1] & reset_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_csr_valid <= 1'b0;
      r_csr_we    <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
    end else begin
      r_csr_valid <= w_accept;
      if (w_accept) begin
        r_csr_we    <= w_req_write[w_sel];
        r_csr_addr  <= w_req_addr[w_sel];
        r_csr_wdata <= w_req_wdata[w_sel];
      end
    end
  end

  assign bus.CSR_valid        = r_csr_valid;
  assign bus.CSR_write_enable = r_csr_we;
  assign bus.CSR_address      = r_csr_addr;
  assign bus.CSR_write_data   = r_csr_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_valid <= '0;
      r_pipe_owner <= '0;
    end else begin
      r_pipe_valid <= {r_pipe_valid[STAGES-2:0], w_accept & ~w_req_write[w_sel]};
      r_pipe_owner <= {r_pipe_owner[STAGES-2:0], w_sel};
    end
  end

  assign w_push[0] = r_pipe_valid[STAGES-1] & ~r_pipe_owner[STAGES-1];
  assign w_push[1] = r_pipe_valid[STAGES-1] &  r_pipe_owner[STAGES-1];
  assign w_pop[0]  = (r_count[0] != '0) & bus.HOST_rsp_ready;
  assign w_pop[1]  = (r_count[1] != '0) & bus.APP_rsp_ready;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 2; r++) begin
        r_wptr[r]  <= '0;
        r_rptr[r]  <= '0;
        r_count[r] <= '0;
        for (int e = 0; e < RSP_DEPTH; e++) begin
          r_mem[r][e] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (w_push[r]) begin
          r_mem[r][r_wptr[r]] <= bus.CSR_read_data;
          r_wptr[r]           <= ptr_next(r_wptr[r]);
        end
        if (w_pop[r]) begin
          r_rptr[r] <= ptr_next(r_rptr[r]);
        end
        case ({w_push[r], w_pop[r]})
          2'b10:   r_count[r] <= r_count[r] + CNT_W'(1);
          2'b01:   r_count[r] <= r_count[r] - CNT_W'(1);
          default: r_count[r] <= r_count[r];
        endcase
      end
    end
  end

  assign bus.HOST_rsp_valid = (r_count[0] != '0);
  assign bus.APP_rsp_valid  = (r_count[1] != '0);
  assign bus.HOST_rsp_rdata = r_mem[0][r_rptr[0]];
  assign bus.APP_rsp_rdata  = r_mem[1][r_rptr[1]];

  // Credits make a push into a full FIFO without a simultaneous pop impossible.
  a_host_ovf: assert property (@(posedge clock) disable iff (!reset_n)
    !(w_push[0] && !w_pop[0] && (r_count[0] == DEPTH_C)));
  a_app_ovf: assert property (@(posedge clock) disable iff (!reset_n)
    !(w_push[1] && !w_pop[1] && (r_count[1] == DEPTH_C)));
endmodule

// File: tb/tb_csr_arbiter.sv
// tb/tb_csr_arbiter.sv - self-checking bench for csr_arbiter
module tb_csr_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  csr_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  csr_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(1), .RSP_DEPTH(DEPTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // CSR target: register file with one cycle of read latency
  logic          mem_init;
  logic [23:0]   mem_salt;
  logic [DW-1:0] tgt_mem [256];
  logic [DW-1:0] tgt_rdata;

  function automatic logic [DW-1:0] init_val(input logic [23:0] salt, input logic [7:0] a);
    return {salt ^ {a, a, a}, a};
  endfunction

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) tgt_mem[i] <= init_val(mem_salt, 8'(i));
    end else if (bus.CSR_valid && bus.CSR_write_enable) begin
      tgt_mem[bus.CSR_address] <= bus.CSR_write_data;
    end
    if (bus.CSR_valid && !bus.CSR_write_enable) tgt_rdata <= tgt_mem[bus.CSR_address];
  end
  assign bus.CSR_read_data = tgt_rdata;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_host(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    bus.HOST_req_valid = v; bus.HOST_req_write = w; bus.HOST_req_address = a; bus.HOST_req_wdata = d;
  endtask

  task automatic set_app(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    bus.APP_req_valid = v; bus.APP_req_write = w; bus.APP_req_address = a; bus.APP_req_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic hv, hw; logic [7:0] ha; logic [31:0] hd;
    logic av, aw; logic [7:0] aa; logic [31:0] ad;
    logic e_hr, e_ar, e_cv, e_cwe; logic [7:0] e_ca; logic [31:0] e_cd;
  } vec_t;
  vec_t vt[9];

  typedef struct { int own; logic [31:0] d; int avail; } rsp_t;
  rsp_t mq[$];
  logic [DW-1:0] m_mem [256];

  function automatic int m_out(input int r);
    int n = 0;
    foreach (mq[i]) if (mq[i].own == r) n++;
    return n;
  endfunction

  function automatic int m_head(input int r);
    foreach (mq[i]) if (mq[i].own == r) return i;
    return -1;
  endfunction

  initial begin
    logic        pend [2];
    logic        pw   [2];
    logic [7:0]  pa   [2];
    logic [31:0] pd   [2];
    logic        rdy  [2];
    logic        elig [2];
    logic        g    [2];
    logic        rv   [2];
    logic [31:0] rd   [2];
    int          m_last;
    logic        pv, pwr;
    logic [7:0]  pad;
    logic [31:0] pdd;
    int          who;

    //             hv    hw    ha     hd            av    aw    aa     ad            hr    ar    cv    cwe   ca     cd
    vt[0] = '{1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0};
    vt[1] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 8'h01, 32'h11111111, 1'b1, 1'b1, 8'h02, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 32'hDEADBEEF};
    vt[3] = '{1'b1, 1'b1, 8'h01, 32'h11111111, 1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 32'h22222222};
    vt[4] = '{1'b1, 1'b1, 8'h03, 32'h33333333, 1'b1, 1'b1, 8'h04, 32'h44444444, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 32'h11111111};
    vt[5] = '{1'b1, 1'b1, 8'h03, 32'h33333333, 1'b1, 1'b1, 8'h06, 32'h66666666, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 32'h44444444};
    vt[6] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h06, 32'h66666666, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 32'h33333333};
    vt[7] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 8'h06, 32'h66666666};
    vt[8] = '{1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 8'h06, 32'h66666666};

    // Reset, with a HOST request held to show ready stays low
    set_host(1'b1, 1'b1, 8'h00, 32'h0);
    set_app(1'b0, 1'b0, 8'h00, 32'h0);
    bus.HOST_rsp_ready = 1'b0;
    bus.APP_rsp_ready = 1'b0;
    mem_salt = 24'h5A5A5A;
    mem_init = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset host_ready", 64'(bus.HOST_req_ready), 64'(0));
    chk("reset csr_valid", 64'(bus.CSR_valid), 64'(0));
    chk("reset csr_we", 64'(bus.CSR_write_enable), 64'(0));
    chk("reset csr_addr", 64'(bus.CSR_address), 64'(0));
    chk("reset csr_wdata", 64'(bus.CSR_write_data), 64'(0));
    chk("reset host_rsp_valid", 64'(bus.HOST_rsp_valid), 64'(0));
    chk("reset app_rsp_valid", 64'(bus.APP_rsp_valid), 64'(0));
    chk("reset host_rdata", 64'(bus.HOST_rsp_rdata), 64'(0));
    set_host(1'b0, 1'b0, 8'h00, 32'h0);
    mem_init = 1'b0;
    next_cycle();
    reset_n = 1'b1;

    // Table: write-only arbitration and CSR issue/hold behaviour
    for (int i = 0; i < 9; i++) begin
      set_host(vt[i].hv, vt[i].hw, vt[i].ha, vt[i].hd);
      set_app(vt[i].av, vt[i].aw, vt[i].aa, vt[i].ad);
      @(negedge clock);
      chk($sformatf("vec%0d host_ready", i), 64'(bus.HOST_req_ready), 64'(vt[i].e_hr));
      chk($sformatf("vec%0d app_ready", i), 64'(bus.APP_req_ready), 64'(vt[i].e_ar));
      chk($sformatf("vec%0d csr_valid", i), 64'(bus.CSR_valid), 64'(vt[i].e_cv));
      chk($sformatf("vec%0d csr_we", i), 64'(bus.CSR_write_enable), 64'(vt[i].e_cwe));
      chk($sformatf("vec%0d csr_addr", i), 64'(bus.CSR_address), 64'(vt[i].e_ca));
      chk($sformatf("vec%0d csr_wdata", i), 64'(bus.CSR_write_data), 64'(vt[i].e_cd));
      chk($sformatf("vec%0d rsp_valids", i), 64'({bus.HOST_rsp_valid, bus.APP_rsp_valid}), 64'(0));
      next_cycle();
    end

    // APP read latency: HOST writes 0x10, APP reads it back
    set_host(1'b1, 1'b1, 8'h10, 32'h12345678);
    @(negedge clock); chk("seqA host write ready", 64'(bus.HOST_req_ready), 64'(1));
    next_cycle();
    set_host(1'b0, 1'b0, 8'h00, 32'h0);
    set_app(1'b1, 1'b0, 8'h10, 32'h0);
    @(negedge clock); chk("seqA app read ready", 64'(bus.APP_req_ready), 64'(1));
    next_cycle();
    set_app(1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clock);
    chk("seqA csr read strobe", 64'({bus.CSR_valid, bus.CSR_write_enable}), 64'(2'b10));
    chk("seqA csr read addr", 64'(bus.CSR_address), 64'(8'h10));
    next_cycle();
    @(negedge clock); chk("seqA app rsp early", 64'(bus.APP_rsp_valid), 64'(0));
    next_cycle();
    bus.APP_rsp_ready = 1'b1;
    @(negedge clock);
    chk("seqA app rsp valid", 64'(bus.APP_rsp_valid), 64'(1));
    chk("seqA app rsp data", 64'(bus.APP_rsp_rdata), 64'(32'h12345678));
    chk("seqA host rsp idle", 64'(bus.HOST_rsp_valid), 64'(0));
    next_cycle();
    bus.APP_rsp_ready = 1'b0;
    @(negedge clock); chk("seqA app rsp popped", 64'(bus.APP_rsp_valid), 64'(0));
    next_cycle();

    // Credit stall: three HOST reads with no response consumption
    set_host(1'b1, 1'b0, 8'h20, 32'h0);
    @(negedge clock); chk("seqB read0 ready", 64'(bus.HOST_req_ready), 64'(1));
    next_cycle();
    set_host(1'b1, 1'b0, 8'h21, 32'h0);
    @(negedge clock); chk("seqB read1 ready", 64'(bus.HOST_req_ready), 64'(1));
    next_cycle();
    set_host(1'b1, 1'b0, 8'h22, 32'h0);
    for (int k = 2; k <= 6; k++) begin
      if (k == 6) bus.HOST_rsp_ready = 1'b1;
      @(negedge clock);
      chk($sformatf("seqB stall c%0d", k), 64'(bus.HOST_req_ready), 64'(0));
      if (k >= 3) chk($sformatf("seqB head c%0d", k), 64'(bus.HOST_rsp_rdata), 64'(init_val(24'h5A5A5A, 8'h20)));
      next_cycle();
    end
    bus.HOST_rsp_ready = 1'b0;
    @(negedge clock);
    chk("seqB read2 after pop", 64'(bus.HOST_req_ready), 64'(1));
    chk("seqB second head", 64'(bus.HOST_rsp_rdata), 64'(init_val(24'h5A5A5A, 8'h21)));
    next_cycle();
    set_host(1'b0, 1'b0, 8'h00, 32'h0);
    bus.HOST_rsp_ready = 1'b1;
    @(negedge clock); chk("seqB drain 21 valid", 64'(bus.HOST_rsp_valid), 64'(1));
    next_cycle();
    @(negedge clock); chk("seqB drain gap", 64'(bus.HOST_rsp_valid), 64'(0));
    next_cycle();
    @(negedge clock);
    chk("seqB drain 22 valid", 64'(bus.HOST_rsp_valid), 64'(1));
    chk("seqB drain 22 data", 64'(bus.HOST_rsp_rdata), 64'(init_val(24'h5A5A5A, 8'h22)));
    next_cycle();
    bus.HOST_rsp_ready = 1'b0;

    // Reset while a read is in flight
    set_host(1'b1, 1'b0, 8'h30, 32'h0);
    @(negedge clock); chk("seqC read ready", 64'(bus.HOST_req_ready), 64'(1));
    next_cycle();
    set_host(1'b0, 1'b0, 8'h00, 32'h0);
    next_cycle();
    reset_n = 1'b0;
    set_host(1'b1, 1'b0, 8'h31, 32'h0);
    #1;
    chk("seqC reset csr_valid", 64'(bus.CSR_valid), 64'(0));
    chk("seqC reset csr_addr", 64'(bus.CSR_address), 64'(0));
    chk("seqC reset host_ready", 64'(bus.HOST_req_ready), 64'(0));
    chk("seqC reset rsp_valid", 64'(bus.HOST_rsp_valid), 64'(0));
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    set_host(1'b0, 1'b0, 8'h00, 32'h0);
    bus.HOST_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("seqC no stale rsp %0d", k), 64'(bus.HOST_rsp_valid), 64'(0));
      next_cycle();
    end

    // Randomized traffic against a queue-based reference model
    mem_salt = 24'($urandom);
    mem_init = 1'b1;
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(mem_salt, 8'(i));
    next_cycle();
    mem_init = 1'b0;
    m_last = 1;
    pv = 1'b0; pwr = 1'b0; pad = '0; pdd = '0;
    for (int r = 0; r < 2; r++) begin pend[r] = 1'b0; pw[r] = 1'b0; pa[r] = '0; pd[r] = '0; end
    mq.delete();
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
          pend[r] = 1'b1;
          pw[r] = ($urandom_range(2, 0) == 0);
          pa[r] = 8'($urandom);
          pd[r] = $urandom;
        end
        rdy[r] = ($urandom_range(3, 0) != 0);
      end
      set_host(pend[0], pw[0], pa[0], pd[0]);
      set_app(pend[1], pw[1], pa[1], pd[1]);
      bus.HOST_rsp_ready = rdy[0];
      bus.APP_rsp_ready = rdy[1];

      for (int r = 0; r < 2; r++) begin
        int h;
        elig[r] = pend[r] && (pw[r] || (m_out(r) < DEPTH));
        h = m_head(r);
        rv[r] = (h >= 0) && (mq[h].avail <= c);
        rd[r] = rv[r] ? mq[h].d : 32'h0;
      end
`ifdef CSR_ARBITER_HOST_PRIORITY_EN
      g[0] = elig[0];
`else
      g[0] = elig[0] && (!elig[1] || (m_last == 1));
`endif
      g[1] = elig[1] && !g[0];

      @(negedge clock);
      chk("rand host_ready", 64'(bus.HOST_req_ready), 64'(g[0]));
      chk("rand app_ready", 64'(bus.APP_req_ready), 64'(g[1]));
      chk("rand host_rsp_valid", 64'(bus.HOST_rsp_valid), 64'(rv[0]));
      chk("rand app_rsp_valid", 64'(bus.APP_rsp_valid), 64'(rv[1]));
      if (rv[0]) chk("rand host_rdata", 64'(bus.HOST_rsp_rdata), 64'(rd[0]));
      if (rv[1]) chk("rand app_rdata", 64'(bus.APP_rsp_rdata), 64'(rd[1]));
      chk("rand csr_valid", 64'(bus.CSR_valid), 64'(pv));
      if (pv) begin
        chk("rand csr_we", 64'(bus.CSR_write_enable), 64'(pwr));
        chk("rand csr_addr", 64'(bus.CSR_address), 64'(pad));
        if (pwr) chk("rand csr_wdata", 64'(bus.CSR_write_data), 64'(pdd));
      end

      for (int r = 0; r < 2; r++) begin
        if (rv[r] && rdy[r]) mq.delete(m_head(r));
      end
      pv = g[0] || g[1];
      if (pv) begin
        who = g[1] ? 1 : 0;
        m_last = who;
        pwr = pw[who];
        pad = pa[who];
        pdd = pd[who];
        if (pw[who]) m_mem[pa[who]] = pd[who];
        else mq.push_back('{who, m_mem[pa[who]], c + 3});
        pend[who] = 1'b0;
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
